ccg_response_misr: RTL and testbench



---
 rtl/ccg_response_misr.sv | 113 +++++++++++
 tb/tb_ccg_response_misr.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ccg_response_misr.sv
// Response compactor: folds 30-bit response vectors into a 32-bit MISR and
// compares the final signature against a golden value after num_vec beats.
module ccg_response_misr #(
   parameter int unsigned          RESP_W = 30,
   parameter int unsigned          SIG_W  = 32,
   parameter logic [SIG_W-1:0]     POLY   = 32'h04C11DB7,
   parameter logic [SIG_W-1:0]     SEED   = 32'hFFFFFFFF,
   parameter int unsigned          CNT_W  = 11
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [CNT_W-1:0]  num_vec,
   input  logic [SIG_W-1:0]  expected_sig,
   input  logic              resp_valid,
   input  logic [RESP_W-1:0] resp_data,
   output logic              resp_ready,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [SIG_W-1:0]  signature,
   output logic [CNT_W-1:0]  vec_count
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [SIG_W-1:0]   sig_q, sig_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   num_q, num_d;
   logic               pass_q, pass_d;
   logic               ready_q, ready_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic [SIG_W-1:0]   misr_next;
   logic [CNT_W-1:0]   cnt_inc;

   always_comb begin
      misr_next = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0)
                  ^ SIG_W'(resp_data);
      cnt_inc   = cnt_q + 1'b1;

      state_d = state_q;
      sig_d   = sig_q;
      cnt_d   = cnt_q;
      num_d   = num_q;
      pass_d  = pass_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               sig_d  = SEED;
               cnt_d  = '0;
               num_d  = num_vec;
               pass_d = 1'b0;
               if (num_vec == '0) begin
                  state_d = S_DONE;
                  pass_d  = (SEED == expected_sig);
               end else begin
                  state_d = S_RUN;
               end
            end
         end
         S_RUN: begin
            // resp_ready is exactly "state is RUN", so valid alone means accept
            if (resp_valid) begin
               sig_d = misr_next;
               cnt_d = cnt_inc;
               if (cnt_inc == num_q) begin
                  state_d = S_DONE;
                  pass_d  = (misr_next == expected_sig);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      ready_d = (state_d == S_RUN);
      busy_d  = (state_d == S_RUN);
      done_d  = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         sig_q   <= '0;
         cnt_q   <= '0;
         num_q   <= '0;
         pass_q  <= 1'b0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sig_q   <= sig_d;
         cnt_q   <= cnt_d;
         num_q   <= num_d;
         pass_q  <= pass_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign resp_ready = ready_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign signature  = sig_q;
   assign vec_count  = cnt_q;

endmodule

// File: tb/tb_ccg_response_misr.sv
// Scoreboard bench for ccg_response_misr: a GF(2) polynomial model predicts each
// run's final signature; a monitor checks it whenever done rises.
module tb_ccg_response_misr;

   localparam logic [31:0] POLY     = 32'h04C11DB7;
   localparam logic [31:0] SEED_DEF = 32'hFFFFFFFF;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_a = 1'b0, start_b = 1'b0;
   logic [10:0] num_vec = '0;
   logic [31:0] expected_sig = '0;
   logic        resp_valid = 1'b0;
   logic [29:0] resp_data = '0;

   logic        ready_a, busy_a, done_a, pass_a;
   logic [31:0] sig_a;
   logic [10:0] cnt_a;
   logic        ready_b, busy_b, done_b, pass_b;
   logic [31:0] sig_b;
   logic [10:0] cnt_b;

   logic        sel = 1'b0;
   logic        ready_s, busy_s, done_s, pass_s;
   logic [31:0] sig_s;
   logic [10:0] cnt_s;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] sig;
      logic [10:0] cnt;
      logic        pass;
   } exp_t;
   exp_t        sb_q[$];
   logic [29:0] vecs[$];

   always #5 clk = ~clk;

   ccg_response_misr dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .num_vec(num_vec),
      .expected_sig(expected_sig), .resp_valid(resp_valid), .resp_data(resp_data),
      .resp_ready(ready_a), .busy(busy_a), .done(done_a), .pass(pass_a),
      .signature(sig_a), .vec_count(cnt_a)
   );

   ccg_response_misr #(.SEED(32'h0000_0000)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .num_vec(num_vec),
      .expected_sig(expected_sig), .resp_valid(resp_valid), .resp_data(resp_data),
      .resp_ready(ready_b), .busy(busy_b), .done(done_b), .pass(pass_b),
      .signature(sig_b), .vec_count(cnt_b)
   );

   always_comb begin
      ready_s = sel ? ready_b : ready_a;
      busy_s  = sel ? busy_b  : busy_a;
      done_s  = sel ? done_b  : done_a;
      pass_s  = sel ? pass_b  : pass_a;
      sig_s   = sel ? sig_b   : sig_a;
      cnt_s   = sel ? cnt_b   : cnt_a;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Signature as polynomial arithmetic: s(x) <- s(x)*x mod P(x) + d(x)
   function automatic logic [31:0] gf_step(input logic [31:0] s, input logic [29:0] d);
      logic [32:0] t;
      t = {s, 1'b0};
      if (t[32]) t = t ^ {1'b1, POLY};
      return t[31:0] ^ {2'b00, d};
   endfunction

   function automatic logic [31:0] fold_all(input logic [31:0] seed);
      logic [31:0] s;
      s = seed;
      foreach (vecs[i]) s = gf_step(s, vecs[i]);
      return s;
   endfunction

   logic prev_done = 1'b0;
   always @(negedge clk) begin
      if (done_s && !prev_done) begin
         if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_unexpected_done: got done=1 expected no pending run");
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("mon_signature", sig_s, e.sig);
            chk("mon_vec_count", 32'(cnt_s), 32'(e.cnt));
            chk("mon_pass", 32'(pass_s), 32'(e.pass));
         end
      end
      prev_done = done_s;
   end

   // dmode: 0 random, 1 all ones, 2 zero, 3 counting, 4 replicated single bit
   // gmode: 0 back-to-back, 1 random gaps, 2 pattern 1,0,1,1,0,1
   task automatic run(input int n, input bit use_b, input int dmode, input int gmode,
                      input bit use_ovr, input logic [31:0] ovr, input bit want_pass,
                      input bit poke_start);
      logic [31:0] seed, msig, exp, run_sig;
      logic [5:0]  pat;
      int          idx, cyc;
      bit          v, acc;
      pat = 6'b101101;
      vecs.delete();
      for (int i = 0; i < n; i++) begin
         case (dmode)
            0: vecs.push_back(30'($urandom));
            1: vecs.push_back('1);
            2: vecs.push_back('0);
            3: vecs.push_back(30'(i + 1));
            default: vecs.push_back($urandom_range(0, 1) != 0 ? '1 : '0);
         endcase
      end
      seed = use_b ? 32'h0 : SEED_DEF;
      msig = fold_all(seed);
      if (use_ovr)        exp = ovr;
      else if (want_pass) exp = msig;
      else                exp = msig ^ (32'h1 << $urandom_range(0, 31));
      sb_q.push_back('{sig: msig, cnt: 11'(n), pass: (msig == exp)});

      @(posedge clk); #1;
      sel = use_b;
      num_vec = 11'(n);
      expected_sig = exp;
      if (use_b) start_b = 1'b1; else start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0; start_b = 1'b0;
      num_vec = 11'($urandom);
      if (n == 0) begin
         chk("zero_done", 32'(done_s), 32'h1);
      end else begin
         chk("start_busy", 32'(busy_s), 32'h1);
         chk("start_done_clr", 32'(done_s), 32'h0);
         chk("start_pass_clr", 32'(pass_s), 32'h0);
         chk("start_seed", sig_s, seed);
         chk("start_cnt", 32'(cnt_s), 32'h0);
      end

      idx = 0; cyc = 0; run_sig = seed;
      while (idx < n && cyc < 8 * n + 20) begin
         case (gmode)
            0: v = 1'b1;
            1: v = ($urandom_range(0, 3) != 0);
            default: v = pat[cyc % 6];
         endcase
         resp_valid = v;
         resp_data = v ? vecs[idx] : 30'($urandom);
         if (poke_start && cyc == 2) begin
            num_vec = 11'd1;
            if (use_b) start_b = 1'b1; else start_a = 1'b1;
         end
         chk("run_ready", 32'(ready_s), 32'h1);
         acc = v && ready_s;
         @(posedge clk); #1;
         start_a = 1'b0; start_b = 1'b0;
         if (acc) begin
            run_sig = gf_step(run_sig, vecs[idx]);
            idx++;
            chk("beat_sig", sig_s, run_sig);
            chk("beat_cnt", 32'(cnt_s), 32'(idx));
         end
         cyc++;
      end
      if (idx < n) begin
         checks++; errors++;
         $display("FAIL run_timeout: got %0d accepts expected %0d", idx, n);
      end

      resp_valid = 1'b1;
      resp_data = 30'($urandom);
      chk("end_ready", 32'(ready_s), 32'h0);
      chk("end_done", 32'(done_s), 32'h1);
      chk("end_busy", 32'(busy_s), 32'h0);
      @(posedge clk); #1;
      chk("hold_cnt", 32'(cnt_s), 32'(n));
      chk("hold_sig", sig_s, msig);
      chk("hold_done", 32'(done_s), 32'h1);
      resp_valid = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_sig", sig_a, 32'h0);
      chk("rst_cnt", 32'(cnt_a), 32'h0);
      chk("rst_flags", {28'h0, ready_a, busy_a, done_a, pass_a}, 32'h0);
      rst_n = 1'b1;

      run(1, 1'b0, 1, 0, 1'b1, 32'hC4C11DB6, 1'b0, 1'b0);
      chk("one_ones_sig", sig_a, 32'hC4C11DB6);
      chk("one_ones_pass", 32'(pass_a), 32'h1);
      run(1, 1'b0, 2, 0, 1'b1, 32'hC4C11DB6, 1'b0, 1'b0);
      chk("one_zero_sig", sig_a, 32'hFB3EE249);
      chk("one_zero_pass", 32'(pass_a), 32'h0);

      run(2, 1'b1, 3, 0, 1'b1, 32'h0, 1'b0, 1'b0);
      chk("seed0_sig", sig_b, 32'h0);
      chk("seed0_pass", 32'(pass_b), 32'h1);

      run(4, 1'b0, 0, 2, 1'b0, 32'h0, 1'b1, 1'b1);

      // Abort a run with reset after three beats
      @(posedge clk); #1;
      sel = 1'b0; num_vec = 11'd10; start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0; resp_valid = 1'b1;
      repeat (3) begin
         resp_data = 30'($urandom);
         @(posedge clk); #1;
      end
      chk("pre_abort_cnt", 32'(cnt_a), 32'd3);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("abort_sig", sig_a, 32'h0);
      chk("abort_cnt", 32'(cnt_a), 32'h0);
      chk("abort_flags", {28'h0, ready_a, busy_a, done_a, pass_a}, 32'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("idle_no_accept", 32'(cnt_a), 32'h0);
      chk("idle_ready", 32'(ready_a), 32'h0);
      resp_valid = 1'b0;

      run(0, 1'b0, 0, 0, 1'b1, SEED_DEF, 1'b0, 1'b0);
      chk("zero_pass", 32'(pass_a), 32'h1);
      chk("zero_sig", sig_a, SEED_DEF);

      for (int k = 0; k < 6; k++)
         run($urandom_range(1, 40), 1'(k % 2), 0, 1, 1'b0, 32'h0,
             ($urandom_range(0, 1) != 0), 1'b0);

      run(1023, 1'b0, 4, 0, 1'b0, 32'h0, 1'b1, 1'b0);
      run(5, 1'b0, 0, 0, 1'b0, 32'h0, 1'b1, 1'b0);
      run(2047, 1'b0, 0, 1, 1'b0, 32'h0, 1'b1, 1'b0);

      repeat (2) @(posedge clk);
      chk("sb_drained", 32'(sb_q.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got no finish expected finish before %0t", $time);
      $fatal(1, "timeout");
   end

endmodule
